// File: rtl/bound_flasher_ctrl.sv
// Bound-flasher lamp controller: six-phase thermometer sweep with configurable bounds,
// a step prescaler and optional flick kickback at the B1+1 / B2+1 turn points.
module bound_flasher_ctrl #(
    parameter int unsigned NUM_LAMPS = 16,
    parameter int unsigned B1        = 5,
    parameter int unsigned B2        = 10,
    parameter int unsigned STEP_DIV  = 1,
    parameter int unsigned KICK_EN   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flick_i,
    output logic [NUM_LAMPS-1:0] lamp_o,
    output logic [2:0]           state_o,
    output logic [1:0]           action_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned LvlW = $clog2(NUM_LAMPS + 1);
    localparam int unsigned PreW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [LvlW-1:0] LvlB1  = LvlW'(B1 + 1);
    localparam logic [LvlW-1:0] LvlB2  = LvlW'(B2 + 1);
    localparam logic [LvlW-1:0] LvlMax = LvlW'(NUM_LAMPS);
    localparam logic [LvlW-1:0] LvlOne = LvlW'(1);
    localparam logic [PreW-1:0] PreMax = PreW'(STEP_DIV - 1);
    localparam logic [PreW-1:0] PreOne = PreW'(1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StUp1  = 3'd1;
    localparam logic [2:0] StDn1  = 3'd2;
    localparam logic [2:0] StUp2  = 3'd3;
    localparam logic [2:0] StDn2  = 3'd4;
    localparam logic [2:0] StUp3  = 3'd5;
    localparam logic [2:0] StDn3  = 3'd6;

    logic [2:0]      state_q, state_d;
    logic [LvlW-1:0] lvl_q, lvl_d;
    logic [PreW-1:0] presc_q, presc_d;
    logic            done_q, done_d;
    logic            tick;
    logic            kick;

    assign tick = (presc_q == PreMax);
    assign kick = (KICK_EN != 0) && flick_i && ((lvl_q == LvlB1) || (lvl_q == LvlB2));

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        presc_d = '0;
        done_d  = 1'b0;
        if (state_q != StIdle) begin
            presc_d = tick ? '0 : presc_q + PreOne;
        end
        // A state-changing tick leaves lvl alone, so every turnaround dwells one tick.
        case (state_q)
            StIdle: begin
                if (flick_i) begin
                    state_d = StUp1;
                end
            end
            StUp1: begin
                if (tick) begin
                    if (lvl_q == LvlB1) state_d = StDn1;
                    else                lvl_d   = lvl_q + LvlOne;
                end
            end
            StDn1: begin
                if (tick) begin
                    if (lvl_q == '0) state_d = StUp2;
                    else             lvl_d   = lvl_q - LvlOne;
                end
            end
            StUp2: begin
                if (tick) begin
                    if (kick)                state_d = StDn1;
                    else if (lvl_q == LvlB2) state_d = StDn2;
                    else                     lvl_d   = lvl_q + LvlOne;
                end
            end
            StDn2: begin
                if (tick) begin
                    if (lvl_q == LvlB1) state_d = StUp3;
                    else                lvl_d   = lvl_q - LvlOne;
                end
            end
            StUp3: begin
                if (tick) begin
                    if (kick)                 state_d = StDn2;
                    else if (lvl_q == LvlMax) state_d = StDn3;
                    else                      lvl_d   = lvl_q + LvlOne;
                end
            end
            StDn3: begin
                if (tick) begin
                    if (lvl_q == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        lvl_d = lvl_q - LvlOne;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                lvl_d   = '0;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lvl_q   <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        lamp_o = '0;
        for (int i = 0; i < int'(NUM_LAMPS); i++) begin
            lamp_o[i] = (LvlW'(i) < lvl_q);
        end
    end

    always_comb begin
        case (state_q)
            StUp1, StUp2, StUp3: action_o = 2'b01;
            StDn1, StDn2, StDn3: action_o = 2'b10;
            default:             action_o = 2'b00;
        endcase
    end

    assign state_o = state_q;
    assign busy_o  = (state_q != StIdle);
    assign done_o  = done_q;

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Directed bench for bound_flasher_ctrl: a scoreboard queue of expected
// {state, action, busy, lamp, done} vectors, popped and asserted against the DUT.
module tb_bound_flasher_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flick0 = 1'b0, flick1 = 1'b0, flick2 = 1'b0;

    logic [15:0] lamp0, lamp1, lamp2;
    logic [2:0]  st0, st1, st2;
    logic [1:0]  act0, act1, act2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [22:0] exp;
    } sb_item_t;

    sb_item_t sb[$];

    always #5 clk = ~clk;

    bound_flasher_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .flick_i(flick0), .lamp_o(lamp0), .state_o(st0),
        .action_o(act0), .busy_o(busy0), .done_o(done0)
    );

    bound_flasher_ctrl #(.STEP_DIV(4)) u_div (
        .clk(clk), .rst_n(rst_n), .flick_i(flick1), .lamp_o(lamp1), .state_o(st1),
        .action_o(act1), .busy_o(busy1), .done_o(done1)
    );

    bound_flasher_ctrl #(.KICK_EN(0)) u_nk (
        .clk(clk), .rst_n(rst_n), .flick_i(flick2), .lamp_o(lamp2), .state_o(st2),
        .action_o(act2), .busy_o(busy2), .done_o(done2)
    );

    function automatic logic [22:0] mk(input int st, input int lvl, input bit dn);
        logic [15:0] t;
        logic [1:0]  a;
        for (int i = 0; i < 16; i++) t[i] = (i < lvl);
        if (st == 1 || st == 3 || st == 5)      a = 2'b01;
        else if (st == 2 || st == 4 || st == 6) a = 2'b10;
        else                                    a = 2'b00;
        return {st[2:0], a, (st != 0), t, dn};
    endfunction

    function automatic logic [22:0] obs(input int sel);
        case (sel)
            0:       return {st0, act0, busy0, lamp0, done0};
            1:       return {st1, act1, busy1, lamp1, done1};
            default: return {st2, act2, busy2, lamp2, done2};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [22:0] e);
        sb_item_t it;
        it.tag = tag;
        it.exp = e;
        sb.push_back(it);
    endtask

    task automatic pop_check(input logic [22:0] o);
        sb_item_t it;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%h expected=<entry>", o);
        end else begin
            it = sb.pop_front();
            assert (o === it.exp) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", it.tag, o, it.exp);
            end
        end
    endtask

    // Ramp lvl from..to in state st, then one dwell entry in the next state.
    task automatic push_ramp(input string pfx, input int st, input int from, input int to,
                             input int nxt);
        int v = from;
        forever begin
            push($sformatf("%s.st%0d.lvl%0d", pfx, st, v), mk(st, v, 1'b0));
            if (v == to) break;
            v = (from <= to) ? v + 1 : v - 1;
        end
        push($sformatf("%s.turn%0d", pfx, nxt), mk(nxt, to, nxt == 0));
    endtask

    task automatic push_full(input string pfx);
        push_ramp(pfx, 1, 1, 6, 2);
        push_ramp(pfx, 2, 5, 0, 3);
        push_ramp(pfx, 3, 1, 11, 4);
        push_ramp(pfx, 4, 10, 6, 5);
        push_ramp(pfx, 5, 7, 16, 6);
        push_ramp(pfx, 6, 15, 0, 0);
    endtask

    task automatic wait_for(input int sel, input logic [2:0] st, input logic [15:0] lp,
                            input int budget, input string tag);
        logic [22:0] o;
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            o = obs(sel);
            if (o[22:20] == st && o[16:1] == lp) found = 1'b1;
        end
        checks++;
        assert (found === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed=timeout(%0d cycles) expected=state%0d lamp %h",
                   tag, budget, st, lp);
        end
    endtask

    initial begin
        // 1: reset values and quiet idle
        #12;
        for (int s = 0; s < 3; s++) begin
            push($sformatf("reset.dut%0d", s), mk(0, 0, 1'b0));
            pop_check(obs(s));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            push($sformatf("idle.c%0d", k), mk(0, 0, 1'b0));
            pop_check(obs(0));
        end

        // 2: full sequence from a one-cycle flick pulse
        flick0 = 1'b1;
        step();
        flick0 = 1'b0;
        push("seq.enter", mk(1, 0, 1'b0));
        pop_check(obs(0));
        push_full("seq");
        for (int k = 0; k < 60; k++) begin
            step();
            pop_check(obs(0));
        end
        push("seq.done_clear", mk(0, 0, 1'b0));
        step();
        pop_check(obs(0));

        // 3: kickback UP2 -> DN1 at lamp 003F
        flick0 = 1'b1;
        step();
        flick0 = 1'b0;
        wait_for(0, 3'd3, 16'h003F, 40, "up2_reach");
        flick0 = 1'b1;
        push("kick_up2", mk(2, 6, 1'b0));
        step();
        pop_check(obs(0));
        push("kick_up2.next", mk(2, 5, 1'b0));
        step();
        pop_check(obs(0));
        flick0 = 1'b0;
        wait_for(0, 3'd0, 16'h0000, 120, "kick_up2.finish");

        // 4: kickback UP3 -> DN2 at lamp 07FF, then resume to FFFF
        flick0 = 1'b1;
        step();
        flick0 = 1'b0;
        wait_for(0, 3'd5, 16'h07FF, 80, "up3_reach");
        flick0 = 1'b1;
        push("kick_up3", mk(4, 11, 1'b0));
        step();
        pop_check(obs(0));
        flick0 = 1'b0;
        push_ramp("kick_up3", 4, 10, 6, 5);
        push_ramp("kick_up3", 5, 7, 16, 6);
        while (sb.size() != 0) begin
            step();
            pop_check(obs(0));
        end
        wait_for(0, 3'd0, 16'h0000, 40, "kick_up3.finish");

        // 5a: STEP_DIV=4 prescaled stepping
        flick1 = 1'b1;
        step();
        flick1 = 1'b0;
        push("div.enter", mk(1, 0, 1'b0));
        pop_check(obs(1));
        for (int k = 0; k < 11; k++) begin
            push($sformatf("div.c%0d", k + 1), mk(1, (k + 1) / 4, 1'b0));
        end
        for (int k = 0; k < 11; k++) begin
            step();
            pop_check(obs(1));
        end
        wait_for(1, 3'd0, 16'h0000, 300, "div.finish");

        // 5b: KICK_EN=0, flick held through every kick point
        flick2 = 1'b1;
        step();
        push("nk.enter", mk(1, 0, 1'b0));
        pop_check(obs(2));
        push_full("nk");
        for (int k = 1; k <= 60; k++) begin
            if (k == 60) flick2 = 1'b0;
            step();
            pop_check(obs(2));
        end
        push("nk.stay_idle", mk(0, 0, 1'b0));
        step();
        pop_check(obs(2));

        // 6: asynchronous reset mid-UP3
        flick0 = 1'b1;
        step();
        flick0 = 1'b0;
        wait_for(0, 3'd5, 16'h0FFF, 80, "up3_0fff");
        #1 rst_n = 1'b0;
        #1;
        push("async_reset", mk(0, 0, 1'b0));
        pop_check(obs(0));
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            push($sformatf("post_reset.c%0d", k), mk(0, 0, 1'b0));
            pop_check(obs(0));
        end
        flick0 = 1'b1;
        step();
        flick0 = 1'b0;
        push("post_reset.start", mk(1, 0, 1'b0));
        pop_check(obs(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bound_flasher_ctrl.md
Name: bound_flasher_ctrl

Overview:
Parametrised bound-flasher lamp controller. It drives an N-lamp thermometer bar through a fixed six-phase up/down sequence with configurable bounds, a step prescaler and optional flick kickback. It exports the phase state and the 2-bit action code (00 hold, 01 increase, 10 decrease) used downstream. It replaces the fixed 16-lamp, one-step-per-clock flasher.

Parameters:
NUM_LAMPS, 16, lamp count; must be >= 4.
B1, 5, first bound lamp index; must satisfy 0 <= B1 < B2.
B2, 10, second bound lamp index; must satisfy B2 < NUM_LAMPS-1.
STEP_DIV, 1, clocks per lamp step; must be >= 1.
KICK_EN, 1, 1 enables kickback; 0 makes flick ignored outside IDLE.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flick  input  1  start/kickback request, sampled synchronously.
lamp  output  NUM_LAMPS  lamp[i] = (i < lvl), thermometer code.
state  output  3  phase encoding.
action  output  2  00 in IDLE; 01 in states 1, 3, 5; 10 in states 2, 4, 6.
busy  output  1  state != IDLE.
done  output  1  one-cycle pulse on the DN3 -> IDLE transition.

Behaviour:
- Reset (async assert, sync to clk on release): lvl=0, state=IDLE(0), prescaler=0, lamp=0, action=00, busy=0, done=0. Reset mid-sequence clears everything immediately.
- Level register lvl: width $clog2(NUM_LAMPS+1), range 0..NUM_LAMPS. It never wraps.
- Prescaler:
  - Held at 0 in IDLE.
  - Otherwise counts 0..STEP_DIV-1; tick when it equals STEP_DIV-1, then it returns to 0.
  - STEP_DIV=1 gives a tick every cycle.
- IDLE(0): if flick=1 at an edge, go to UP1 at that edge (not tick-gated). The first lvl change occurs STEP_DIV cycles later.
- On each tick, by state:
  - UP1(1): if lvl==B1+1, go to DN1; else lvl+1.
  - DN1(2): if lvl==0, go to UP2; else lvl-1.
  - UP2(3): if KICK_EN && flick && (lvl==B1+1 || lvl==B2+1), go to DN1. Else if lvl==B2+1, go to DN2. Else lvl+1.
  - DN2(4): if lvl==B1+1, go to UP3; else lvl-1.
  - UP3(5): if KICK_EN && flick && (lvl==B1+1 || lvl==B2+1), go to DN2. Else if lvl==NUM_LAMPS, go to DN3. Else lvl+1.
  - DN3(6): if lvl==0, go to IDLE and pulse done; else lvl-1.
- A tick that changes state never changes lvl, so each turnaround dwells one tick at its bound.
- Kickback has priority over the bound transition in the same tick.
- Flick held high at a kick point keeps bouncing UP3 <-> DN2 (or UP2 <-> DN1) without lvl change. This is required behaviour.
- Flick outside IDLE and away from kick points is ignored. Flick in DN states is ignored.
- Unused state encoding 7: go to IDLE next edge, lvl cleared.
- action, busy and state are combinational from the state register. lamp is combinational from lvl. done is registered.

Test Plan:
1. Reset with defaults -> lamp=16'h0000, state=0, action=00, busy=0, done=0; flick=0 for 20 cycles -> no change.
2. One-cycle flick pulse, STEP_DIV=1 -> lamp ramps 0001..003F, down to 0000, up to 07FF, down to 003F, up to FFFF, down to 0000. Phase lengths 7/7/12/6/11/17 ticks; done pulses exactly 60 cycles after entering UP1; state=0.
3. In UP2, hold flick=1 on the tick where lamp=16'h003F -> state=2, action=10; next tick lamp=16'h001F.
4. In UP3, assert flick on the tick where lamp=16'h07FF -> state=4; lamp descends to 16'h003F, then UP3 resumes (release flick) and reaches 16'hFFFF.
5. STEP_DIV=4 -> first lamp change 4 cycles after flick; lamp constant across each 4-cycle window. KICK_EN=0 -> flick at 003F in UP2 ignored and sequence completes in 60 ticks.
6. Drop rst_n asynchronously mid-UP3 (lamp=16'h0FFF) -> lamp=0, state=0 before the next clk edge. After release, IDLE awaits flick.
